bf_uart_bridge: RTL and testbench

Host-side I/O bridge for the brainfuck interpreter: converts a serial UART line into the interpreter's byte input stream, and its byte output stream back into UART frames. It sits between the FPGA pins and the interpreter. Its stream ports connect directly to the interpreter's `machine_input*` and `machine_output*` ports. RX is buffered in a small FIFO; TX holds one byte in flight.

---
 rtl/bf_uart_bridge.sv | 254 +++++++++++++++++++++++++
 tb/tb_bf_uart_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bf_uart_bridge.sv
// bf_uart_bridge: UART <-> byte-stream bridge for the brainfuck interpreter.
// RX: 2-flop synchroniser, mid-bit sampling FSM, small FIFO toward the
// interpreter input stream. TX: single byte in flight, one-cycle line lag
// behind the TX state so each bit is a clean registered output.
module bf_uart_bridge #(
    parameter int CLKS_PER_BIT = 16,
    parameter int WORD_SIZE    = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 uart_rx,
    output logic                 uart_tx,
    output logic [WORD_SIZE-1:0] in_data,
    output logic                 in_valid,
    input  logic                 in_ready,
    input  logic [WORD_SIZE-1:0] out_data,
    input  logic                 out_valid,
    output logic                 out_ready,
    output logic                 rx_overrun,
    output logic                 frame_error
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(WORD_SIZE + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_SIZE - 1);
    localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    // RX synchroniser and state
    logic                 rx_meta_p0;
    logic                 rx_sync_p1;
    rx_state_t            rx_state;
    logic [CNT_W-1:0]     rx_cnt;
    logic [IDX_W-1:0]     rx_idx;
    logic [WORD_SIZE-1:0] rx_shift;
    logic                 push_vld_p2;

    // RX FIFO
    logic [WORD_SIZE-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       fifo_cnt;
    logic                 fifo_full;
    logic                 pop;
    logic                 push_ok;

    // TX state
    tx_state_t            tx_state;
    logic [CNT_W-1:0]     tx_cnt;
    logic [IDX_W-1:0]     tx_idx;
    logic [WORD_SIZE-1:0] tx_shift;
    logic                 tx_accept;

    // Bring the asynchronous line into the clk domain; idle-high after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_p0 <= 1'b1;
            rx_sync_p1 <= 1'b1;
        end else begin
            rx_meta_p0 <= uart_rx;
            rx_sync_p1 <= rx_meta_p0;
        end
    end

    // RX frame FSM: mid-bit sampling, start-glitch rejection, stop-bit check
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state    <= RX_IDLE;
            rx_cnt      <= '0;
            rx_idx      <= '0;
            push_vld_p2 <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            push_vld_p2 <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    if (!rx_sync_p1) begin
                        rx_state <= RX_START;
                        rx_cnt   <= HALF_BIT;
                    end
                end
                RX_START: begin
                    if (rx_cnt == '0) begin
                        if (!rx_sync_p1) begin
                            rx_state <= RX_DATA;
                            rx_cnt   <= FULL_BIT;
                            rx_idx   <= '0;
                        end else begin
                            rx_state <= RX_IDLE;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt <= FULL_BIT;
                        if (rx_idx == LAST_IDX) begin
                            rx_state <= RX_STOP;
                        end else begin
                            rx_idx <= rx_idx + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                RX_STOP: begin
                    if (rx_cnt == '0) begin
                        if (rx_sync_p1) begin
                            push_vld_p2 <= 1'b1;
                        end else begin
                            frame_error <= 1'b1;
                        end
                        rx_state <= RX_IDLE;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_state <= RX_IDLE;
            endcase
        end
    end

    // RX data shift, LSB first; holds the finished word until the next frame's data phase
    always_ff @(posedge clk) begin
        if (rx_state == RX_DATA && rx_cnt == '0) begin
            rx_shift <= {rx_sync_p1, rx_shift[WORD_SIZE-1:1]};
        end
    end

    assign pop       = in_valid && in_ready;
    assign fifo_full = (fifo_cnt == FIFO_FULL_CNT);
    assign push_ok   = push_vld_p2 && (!fifo_full || pop);
    assign in_valid  = (fifo_cnt != '0);
    assign in_data   = fifo_mem[rd_ptr];

    // FIFO pointers, occupancy and sticky overrun flag
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_cnt   <= '0;
            rx_overrun <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (push_vld_p2 && !push_ok) begin
                rx_overrun <= 1'b1;
            end
        end
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr] <= rx_shift;
        end
    end

    assign out_ready = (tx_state == TX_IDLE) && !rst;
    assign tx_accept = out_valid && out_ready;

    // TX frame FSM; uart_tx follows the state one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_idx   <= '0;
            uart_tx  <= 1'b1;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    uart_tx <= 1'b1;
                    if (tx_accept) begin
                        tx_state <= TX_START;
                        tx_cnt   <= FULL_BIT;
                    end
                end
                TX_START: begin
                    uart_tx <= 1'b0;
                    if (tx_cnt == '0) begin
                        tx_state <= TX_DATA;
                        tx_cnt   <= FULL_BIT;
                        tx_idx   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                TX_DATA: begin
                    uart_tx <= tx_shift[0];
                    if (tx_cnt == '0) begin
                        tx_cnt <= FULL_BIT;
                        if (tx_idx == LAST_IDX) begin
                            tx_state <= TX_STOP;
                        end else begin
                            tx_idx <= tx_idx + 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                TX_STOP: begin
                    uart_tx <= 1'b1;
                    if (tx_cnt == '0) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: begin
                    uart_tx  <= 1'b1;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    // TX data: load on accept, shift right at the end of each data bit
    always_ff @(posedge clk) begin
        if (tx_accept) begin
            tx_shift <= out_data;
        end else if (tx_state == TX_DATA && tx_cnt == '0) begin
            tx_shift <= tx_shift >> 1;
        end
    end

endmodule

// File: tb/tb_bf_uart_bridge.sv
// Directed bench for bf_uart_bridge with CLKS_PER_BIT=4, WORD_SIZE=8, FIFO_DEPTH=4.
module tb_bf_uart_bridge;

    localparam int CPB   = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rx_drive = 1'b1;
    logic         loop_en = 1'b0;
    logic         uart_rx;
    logic         uart_tx;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready = 1'b0;
    logic [W-1:0] out_data = '0;
    logic         out_valid = 1'b0;
    logic         out_ready;
    logic         rx_overrun;
    logic         frame_error;

    int checks = 0;
    int passes = 0;

    logic [W-1:0] rxq [$];
    int           vcycles = 0;

    assign uart_rx = loop_en ? uart_tx : rx_drive;

    always #5 clk = ~clk;

    bf_uart_bridge #(
        .CLKS_PER_BIT(CPB),
        .WORD_SIZE   (W),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .uart_tx    (uart_tx),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .rx_overrun (rx_overrun),
        .frame_error(frame_error)
    );

    // Record every valid cycle and every completed input-stream transfer
    always @(negedge clk) begin
        if (!rst && in_valid) begin
            vcycles <= vcycles + 1;
            if (in_ready) rxq.push_back(in_data);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_n;
        logic       exp_fe;
    } rx_vec_t;

    rx_vec_t    rxv [6];
    logic [7:0] txv [4];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        rx_drive = 1'b0;
        repeat (CPB) tick();
        for (int i = 0; i < W; i++) begin
            rx_drive = b[i];
            repeat (CPB) tick();
        end
        rx_drive = stop;
        repeat (CPB) tick();
        rx_drive = 1'b1;
    endtask

    initial begin
        int base;
        int vbase;
        int lowcnt;
        int n;
        logic [39:0] seen;
        logic [39:0] expv;
        logic [9:0]  frame;
        logic [7:0]  lb [3];

        rxv[0] = '{8'h3C, 1'b1, 1, 1'b0};
        rxv[1] = '{8'h00, 1'b1, 1, 1'b0};
        rxv[2] = '{8'hFF, 1'b1, 1, 1'b0};
        rxv[3] = '{8'hA5, 1'b1, 1, 1'b0};
        rxv[4] = '{8'h55, 1'b0, 0, 1'b1};
        rxv[5] = '{8'h80, 1'b1, 1, 1'b0};
        txv[0] = 8'hA5;
        txv[1] = 8'h3C;
        txv[2] = 8'h00;
        txv[3] = 8'hFF;
        lb[0]  = 8'h00;
        lb[1]  = 8'hFF;
        lb[2]  = 8'h80;

        // Reset behaviour
        rst = 1'b1;
        repeat (3) tick();
        check("rst_uart_tx", uart_tx, 1);
        check("rst_in_valid", in_valid, 0);
        check("rst_out_ready", out_ready, 0);
        check("rst_flags", {rx_overrun, frame_error}, 0);
        rst = 1'b0;
        #1;
        check("rel_out_ready", out_ready, 1);
        tick();
        check("rel_uart_tx", uart_tx, 1);

        // TX frames
        foreach (txv[v]) begin
            out_data  = txv[v];
            out_valid = 1'b1;
            tick();
            out_valid = 1'b0;
            out_data  = 8'hEE;
            frame = {1'b1, txv[v], 1'b0};
            lowcnt = 0;
            for (int k = 0; k < 40; k++) begin
                if (!out_ready) lowcnt++;
                expv[k] = frame[k / CPB];
                tick();
                seen[k] = uart_tx;
            end
            check($sformatf("tx_bits_%0h", txv[v]), seen, expv);
            check($sformatf("tx_ready_low_%0h", txv[v]), lowcnt, 40);
            check($sformatf("tx_ready_back_%0h", txv[v]), out_ready, 1);
        end

        // RX frames, one reset per vector
        in_ready = 1'b1;
        foreach (rxv[v]) begin
            do_reset();
            base  = rxq.size();
            vbase = vcycles;
            send_frame(rxv[v].data, rxv[v].stop);
            repeat (3 * CPB) tick();
            check($sformatf("rx_count_%0h", rxv[v].data), rxq.size() - base, rxv[v].exp_n);
            check($sformatf("rx_vcycles_%0h", rxv[v].data), vcycles - vbase, rxv[v].exp_n);
            if (rxv[v].exp_n == 1 && rxq.size() > base)
                check($sformatf("rx_data_%0h", rxv[v].data), rxq[base], rxv[v].data);
            check($sformatf("rx_fe_%0h", rxv[v].data), frame_error, rxv[v].exp_fe);
            check($sformatf("rx_ovr_%0h", rxv[v].data), rx_overrun, 0);
        end

        // Glitch on the line, then a normal frame
        do_reset();
        base = rxq.size();
        rx_drive = 1'b0;
        tick();
        rx_drive = 1'b1;
        repeat (20) tick();
        check("glitch_valid", in_valid, 0);
        check("glitch_flags", {rx_overrun, frame_error}, 0);
        send_frame(8'h96, 1'b1);
        repeat (3 * CPB) tick();
        check("post_glitch_count", rxq.size() - base, 1);
        if (rxq.size() > base) check("post_glitch_data", rxq[base], 8'h96);

        // Overrun: five frames into a four-entry FIFO, then drain
        do_reset();
        in_ready = 1'b0;
        for (int b = 1; b <= 5; b++) send_frame(8'(b), 1'b1);
        repeat (3 * CPB) tick();
        check("ovr_flag", rx_overrun, 1);
        check("ovr_fe", frame_error, 0);
        check("ovr_valid", in_valid, 1);
        in_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), {in_valid, in_data}, {1'b1, 8'(i + 1)});
            tick();
        end
        check("drain_empty", in_valid, 0);
        check("ovr_sticky", rx_overrun, 1);

        // Loopback, back-to-back bytes
        do_reset();
        loop_en = 1'b1;
        base = rxq.size();
        foreach (lb[i]) begin
            n = 0;
            while (!out_ready && n < 200) begin
                tick();
                n++;
            end
            check($sformatf("lb_ready_%0d", i), out_ready, 1);
            out_data  = lb[i];
            out_valid = 1'b1;
            tick();
            out_valid = 1'b0;
        end
        n = 0;
        while (rxq.size() - base < 3 && n < 300) begin
            tick();
            n++;
        end
        check("lb_count", rxq.size() - base, 3);
        foreach (lb[i])
            if (rxq.size() > base + i) check($sformatf("lb_byte_%0d", i), rxq[base + i], lb[i]);
        check("lb_flags", {rx_overrun, frame_error}, 0);

        // Reset in the middle of a looped-back frame
        repeat (10) tick();
        base = rxq.size();
        out_data  = 8'h5A;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        repeat (18) tick();
        rst = 1'b1;
        tick();
        check("midrst_uart_tx", uart_tx, 1);
        rst = 1'b0;
        repeat (60) tick();
        check("midrst_no_push", rxq.size() - base, 0);
        check("midrst_valid", in_valid, 0);
        check("midrst_flags", {rx_overrun, frame_error}, 0);

        // Recovery after the aborted frame
        out_data  = 8'hC3;
        out_valid = 1'b1;
        tick();
        out_valid = 1'b0;
        repeat (60) tick();
        check("recover_count", rxq.size() - base, 1);
        if (rxq.size() > base) check("recover_data", rxq[base], 8'hC3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
